// File: rtl/dsp_result_packer.sv
// dsp_result_packer
//
// Purpose: takes the 48-bit DSP post-adder result, rounds it half-up, shifts it
// arithmetically right by SHIFT, then saturates or wraps it to an OUT_W-bit word.
// The result passes through one register stage (S1) and is buffered in a small
// first-word-fall-through FIFO. A valid/ready handshake feeds the next consumer.
//
// Ports:
//   CLK         single clock, rising edge
//   RSTN        asynchronous active-low reset
//   P           signed DSP result (IN_W bits)
//   CARRYOUT    DSP carry, travels with the word
//   P_VALID     P/CARRYOUT valid this cycle
//   P_READY     packer accepts this cycle (registered state only)
//   SAT_EN      1 = saturate, 0 = wrap; sampled with each accepted word
//   DOUT        FIFO head word (0 while empty)
//   DOUT_CARRY  carry bit of head word (0 while empty)
//   DOUT_SAT    head word was out of range (0 while empty)
//   DOUT_VALID  FIFO non-empty
//   DOUT_READY  consumer pops the head when high with DOUT_VALID
//   COUNT       words held in the FIFO (S1 not included)
//   OVF_STICKY  set when an out-of-range word enters the FIFO
//   CLR_OVF     synchronous clear of OVF_STICKY (a same-edge set wins)
module dsp_result_packer #(
  parameter int IN_W  = 48,
  parameter int OUT_W = 18,
  parameter int SHIFT = 17,
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic             CLK,
  input  logic             RSTN,
  input  logic [IN_W-1:0]  P,
  input  logic             CARRYOUT,
  input  logic             P_VALID,
  output logic             P_READY,
  input  logic             SAT_EN,
  output logic [OUT_W-1:0] DOUT,
  output logic             DOUT_CARRY,
  output logic             DOUT_SAT,
  output logic             DOUT_VALID,
  input  logic             DOUT_READY,
  output logic [AW:0]      COUNT,
  output logic             OVF_STICKY,
  input  logic             CLR_OVF
);

  // One extra bit so that adding the rounding constant cannot overflow.
  localparam int EW = IN_W + 1;
  localparam int EN = OUT_W + 2;  // stored entry: {carry, flag, word}

  localparam logic signed [EW-1:0] Q_MAX = (EW'(1) << (OUT_W - 1)) - EW'(1);
  localparam logic signed [EW-1:0] Q_MIN = -(EW'(1) << (OUT_W - 1));
  localparam logic [OUT_W-1:0] SAT_POS = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0] SAT_NEG = {1'b1, {(OUT_W-1){1'b0}}};

  // ---------------------------------------------------------------- datapath
  logic signed [EW-1:0] p_ext;
  logic signed [EW-1:0] p_rnd;
  logic signed [EW-1:0] q;
  logic                 q_over;
  logic                 q_under;
  logic [OUT_W-1:0]     word_next;

  assign p_ext = $signed({P[IN_W-1], P});

  generate
    if (SHIFT > 0) begin : g_round
      localparam logic [EW-1:0] RND = EW'(1) << (SHIFT - 1);
      assign p_rnd = $signed(p_ext + RND);
    end else begin : g_no_round
      assign p_rnd = p_ext;
    end
  endgenerate

  assign q       = p_rnd >>> SHIFT;
  assign q_over  = q > Q_MAX;
  assign q_under = q < Q_MIN;

  always_comb begin
    word_next = q[OUT_W-1:0];
    if (SAT_EN && q_over) begin
      word_next = SAT_POS;
    end else if (SAT_EN && q_under) begin
      word_next = SAT_NEG;
    end
  end

  // ---------------------------------------------------------------- control
  logic             s1_valid_reg;
  logic [OUT_W-1:0] s1_word_reg;
  logic             s1_carry_reg;
  logic             s1_flag_reg;
  logic [AW-1:0]    wr_ptr_reg, wr_ptr_next;
  logic [AW-1:0]    rd_ptr_reg, rd_ptr_next;
  logic [AW:0]      count_reg, count_next;
  logic             ovf_reg, ovf_next;
  logic [EN-1:0]    mem [DEPTH];
  logic [EN-1:0]    head;
  logic             accept;
  logic             wr_en;
  logic             pop;
  logic             empty;

  // Space is reserved for the word in S1. A pop on the same edge does not
  // count, so S1 always has a free FIFO slot when it is written.
  assign P_READY = ({1'b0, count_reg} + (AW+2)'(s1_valid_reg)) < (AW+2)'(DEPTH);
  assign accept  = P_VALID & P_READY;
  assign wr_en   = s1_valid_reg;
  assign empty   = (count_reg == '0);
  assign pop     = ~empty & DOUT_READY;

  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;
    ovf_next    = ovf_reg;
    if (wr_en) wr_ptr_next = wr_ptr_reg + AW'(1);
    if (pop)   rd_ptr_next = rd_ptr_reg + AW'(1);
    case ({wr_en, pop})
      2'b10:   count_next = count_reg + (AW+1)'(1);
      2'b01:   count_next = count_reg - (AW+1)'(1);
      default: count_next = count_reg;
    endcase
    if (wr_en && s1_flag_reg) begin
      ovf_next = 1'b1;
    end else if (CLR_OVF) begin
      ovf_next = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      s1_valid_reg <= 1'b0;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      ovf_reg      <= 1'b0;
    end else begin
      s1_valid_reg <= accept;
      wr_ptr_reg   <= wr_ptr_next;
      rd_ptr_reg   <= rd_ptr_next;
      count_reg    <= count_next;
      ovf_reg      <= ovf_next;
    end
  end

  // S1 payload is only meaningful while s1_valid_reg is set, so it has no reset.
  always_ff @(posedge CLK) begin
    if (accept) begin
      s1_word_reg  <= word_next;
      s1_carry_reg <= CARRYOUT;
      s1_flag_reg  <= q_over | q_under;
    end
  end

  // FIFO storage is not reset; empty masking hides stale contents.
  always_ff @(posedge CLK) begin
    if (wr_en) begin
      mem[wr_ptr_reg] <= {s1_carry_reg, s1_flag_reg, s1_word_reg};
    end
  end

  assign head       = mem[rd_ptr_reg];
  assign DOUT_VALID = ~empty;
  assign DOUT       = empty ? '0   : head[OUT_W-1:0];
  assign DOUT_SAT   = empty ? 1'b0 : head[OUT_W];
  assign DOUT_CARRY = empty ? 1'b0 : head[OUT_W+1];
  assign COUNT      = count_reg;
  assign OVF_STICKY = ovf_reg;

endmodule

// File: tb/tb_dsp_result_packer.sv
// tb_dsp_result_packer
//
// Directed bench for dsp_result_packer. A queue-based reference model computes
// each word with integer arithmetic and tracks FIFO occupancy. A negedge
// compare process checks every output against that model. Hand-computed
// literal checks pin rounding, saturation, latency, full/empty and reset.
module tb_dsp_result_packer;

  localparam int IN_W  = 48;
  localparam int OUT_W = 18;
  localparam int SHIFT = 17;
  localparam int DEPTH = 4;
  localparam int AW    = 2;

  localparam longint QMAX = (longint'(1) << (OUT_W - 1)) - 1;
  localparam longint QMIN = -(longint'(1) << (OUT_W - 1));

  logic             CLK;
  logic             RSTN;
  logic [IN_W-1:0]  P;
  logic             CARRYOUT;
  logic             P_VALID;
  logic             P_READY;
  logic             SAT_EN;
  logic [OUT_W-1:0] DOUT;
  logic             DOUT_CARRY;
  logic             DOUT_SAT;
  logic             DOUT_VALID;
  logic             DOUT_READY;
  logic [AW:0]      COUNT;
  logic             OVF_STICKY;
  logic             CLR_OVF;

  dsp_result_packer #(
    .IN_W(IN_W), .OUT_W(OUT_W), .SHIFT(SHIFT), .DEPTH(DEPTH), .AW(AW)
  ) dut (
    .CLK(CLK), .RSTN(RSTN), .P(P), .CARRYOUT(CARRYOUT), .P_VALID(P_VALID),
    .P_READY(P_READY), .SAT_EN(SAT_EN), .DOUT(DOUT), .DOUT_CARRY(DOUT_CARRY),
    .DOUT_SAT(DOUT_SAT), .DOUT_VALID(DOUT_VALID), .DOUT_READY(DOUT_READY),
    .COUNT(COUNT), .OVF_STICKY(OVF_STICKY), .CLR_OVF(CLR_OVF)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  int n_vec  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------- model
  typedef struct {
    logic [OUT_W-1:0] w;
    bit               c;
    bit               f;
  } item_t;

  function automatic item_t proc(input logic [IN_W-1:0] p, input bit sat, input bit c);
    item_t  r;
    longint v;
    longint qv;
    v = longint'($signed(p));
    if (SHIFT > 0) v = v + (longint'(1) << (SHIFT - 1));
    qv  = v >>> SHIFT;
    r.c = c;
    r.f = (qv > QMAX) || (qv < QMIN);
    r.w = qv[OUT_W-1:0];
    if (sat && qv > QMAX) r.w = {1'b0, {(OUT_W-1){1'b1}}};
    if (sat && qv < QMIN) r.w = {1'b1, {(OUT_W-1){1'b0}}};
    return r;
  endfunction

  item_t exp_q[$];
  item_t s1_item;
  bit    s1p   = 1'b0;
  bit    ovf_m = 1'b0;

  always @(posedge CLK or negedge RSTN) begin : model_blk
    bit acc;
    if (!RSTN) begin
      exp_q.delete();
      s1p   = 1'b0;
      ovf_m = 1'b0;
    end else begin
      acc = P_VALID && ((exp_q.size() + int'(s1p)) < DEPTH);
      if (exp_q.size() > 0 && DOUT_READY) void'(exp_q.pop_front());
      if (s1p && s1_item.f) ovf_m = 1'b1;
      else if (CLR_OVF) ovf_m = 1'b0;
      if (s1p) exp_q.push_back(s1_item);
      s1p = acc;
      if (acc) s1_item = proc(P, SAT_EN, CARRYOUT);
    end
  end

  always @(negedge CLK) begin : compare_blk
    chk("m_p_ready", 64'(P_READY), 64'((exp_q.size() + int'(s1p)) < DEPTH));
    chk("m_count", 64'(COUNT), 64'(exp_q.size()));
    chk("m_dout_valid", 64'(DOUT_VALID), 64'(exp_q.size() > 0));
    chk("m_ovf", 64'(OVF_STICKY), 64'(ovf_m));
    if (exp_q.size() > 0) begin
      chk("m_dout", 64'(DOUT), 64'(exp_q[0].w));
      chk("m_dout_carry", 64'(DOUT_CARRY), 64'(exp_q[0].c));
      chk("m_dout_sat", 64'(DOUT_SAT), 64'(exp_q[0].f));
    end else begin
      chk("m_dout_empty", 64'({DOUT_CARRY, DOUT_SAT, DOUT}), 64'(0));
    end
  end

  // ---------------------------------------------------------------- stimulus
  // One word in, checked against a literal, then popped.
  task automatic single(input logic [IN_W-1:0] p, input bit sat, input bit c,
                        input logic [OUT_W-1:0] ew, input bit es);
    @(posedge CLK); #1;
    P = p; SAT_EN = sat; CARRYOUT = c; P_VALID = 1'b1; DOUT_READY = 1'b0;
    @(posedge CLK); #1;
    P_VALID = 1'b0;
    @(negedge CLK);
    chk("lit_lat_edge1_valid", 64'(DOUT_VALID), 64'(0));
    @(negedge CLK);
    chk("lit_lat_edge2_valid", 64'(DOUT_VALID), 64'(1));
    chk("lit_dout", 64'(DOUT), 64'(ew));
    chk("lit_dout_sat", 64'(DOUT_SAT), 64'(es));
    chk("lit_dout_carry", 64'(DOUT_CARRY), 64'(c));
    @(posedge CLK); #1;
    DOUT_READY = 1'b1;
    @(posedge CLK); #1;
    DOUT_READY = 1'b0;
    @(negedge CLK);
    chk("lit_count_after_pop", 64'(COUNT), 64'(0));
  endtask

  initial begin : main_blk
    int n_acc;
    RSTN = 1'b0; P = '0; CARRYOUT = 1'b0; P_VALID = 1'b0; SAT_EN = 1'b1;
    DOUT_READY = 1'b0; CLR_OVF = 1'b0;
    repeat (3) @(posedge CLK);
    #1 RSTN = 1'b1;
    @(negedge CLK);
    chk("lit_idle_p_ready", 64'(P_READY), 64'(1));
    chk("lit_idle_valid", 64'(DOUT_VALID), 64'(0));
    chk("lit_idle_count", 64'(COUNT), 64'(0));
    chk("lit_idle_ovf", 64'(OVF_STICKY), 64'(0));

    // Rounding
    single(48'd393216, 1'b1, 1'b1, 18'd3, 1'b0);
    single(48'd458752, 1'b1, 1'b0, 18'd4, 1'b0);
    single(48'hFFFF_FFFF_0000, 1'b1, 1'b1, 18'd0, 1'b0);      // -65536
    single(48'hFFFF_FFFD_0000, 1'b1, 1'b0, 18'h3FFFF, 1'b0);  // -196608 -> -1
    chk("lit_ovf_after_round", 64'(OVF_STICKY), 64'(0));

    // Saturation and wrap
    single(48'h0100_0000_0000, 1'b1, 1'b0, 18'h1FFFF, 1'b1);  // +2^40
    chk("lit_ovf_set", 64'(OVF_STICKY), 64'(1));
    single(48'hFF00_0000_0000, 1'b1, 1'b1, 18'h20000, 1'b1);  // -2^40
    single(48'h0100_0000_0000, 1'b0, 1'b0, 18'h00000, 1'b1);  // wrap

    @(posedge CLK); #1 CLR_OVF = 1'b1;
    @(posedge CLK); #1 CLR_OVF = 1'b0;
    @(negedge CLK);
    chk("lit_ovf_cleared", 64'(OVF_STICKY), 64'(0));

    // Clear coincident with a flagged write: set wins
    @(posedge CLK); #1;
    P = 48'h0100_0000_0000; SAT_EN = 1'b1; P_VALID = 1'b1;
    @(posedge CLK); #1;
    P_VALID = 1'b0; CLR_OVF = 1'b1;
    @(posedge CLK); #1;
    CLR_OVF = 1'b0;
    @(negedge CLK);
    chk("lit_ovf_set_wins", 64'(OVF_STICKY), 64'(1));
    @(posedge CLK); #1 DOUT_READY = 1'b1;
    @(posedge CLK); #1 DOUT_READY = 1'b0;

    // Full
    n_acc = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge CLK); #1;
      P = 48'(i + 1) << SHIFT; CARRYOUT = i[0]; P_VALID = 1'b1;
      @(negedge CLK);
      if (P_VALID && P_READY) n_acc++;
    end
    @(posedge CLK); #1 P_VALID = 1'b0;
    @(negedge CLK);
    chk("lit_full_accepts", 64'(n_acc), 64'(4));
    chk("lit_full_count", 64'(COUNT), 64'(4));
    chk("lit_full_p_ready", 64'(P_READY), 64'(0));
    @(posedge CLK); #1 DOUT_READY = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge CLK);
      chk("lit_full_pop_order", 64'(DOUT), 64'(k));
    end
    @(negedge CLK);
    chk("lit_drained_p_ready", 64'(P_READY), 64'(1));
    chk("lit_drained_count", 64'(COUNT), 64'(0));

    // Simultaneous push and pop
    for (int i = 0; i < 10; i++) begin
      @(posedge CLK); #1;
      P = 48'(i + 10) << SHIFT; CARRYOUT = ~i[0]; P_VALID = 1'b1;
      @(negedge CLK);
      if (i >= 2) chk("lit_stream_count", 64'(COUNT), 64'(1));
    end
    @(posedge CLK); #1 P_VALID = 1'b0;

    // Empty pop (DOUT_READY still high)
    repeat (3) @(negedge CLK);
    chk("lit_empty_count", 64'(COUNT), 64'(0));
    chk("lit_empty_dout", 64'(DOUT), 64'(0));
    chk("lit_empty_valid", 64'(DOUT_VALID), 64'(0));
    single(48'd393216, 1'b1, 1'b0, 18'd3, 1'b0);

    // Reset mid-operation with 3 words buffered
    for (int i = 0; i < 3; i++) begin
      @(posedge CLK); #1;
      P = (i == 1) ? 48'h0100_0000_0000 : 48'(i + 7) << SHIFT;
      SAT_EN = 1'b1; CARRYOUT = 1'b1; P_VALID = 1'b1;
    end
    @(posedge CLK); #1 P_VALID = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
    chk("lit_pre_reset_count", 64'(COUNT), 64'(3));
    chk("lit_pre_reset_ovf", 64'(OVF_STICKY), 64'(1));
    #2 RSTN = 1'b0;
    #1;
    chk("lit_rst_p_ready", 64'(P_READY), 64'(1));
    chk("lit_rst_valid", 64'(DOUT_VALID), 64'(0));
    chk("lit_rst_count", 64'(COUNT), 64'(0));
    chk("lit_rst_dout", 64'({DOUT_CARRY, DOUT_SAT, DOUT}), 64'(0));
    chk("lit_rst_ovf", 64'(OVF_STICKY), 64'(0));
    @(posedge CLK); #1 RSTN = 1'b1;
    repeat (2) @(negedge CLK);
    chk("lit_post_reset_count", 64'(COUNT), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/dsp_result_packer.md
# dsp_result_packer

Downstream stage of the DSP slice. Consumes the 48-bit post-adder result `P` and `CARRYOUT`, then rounds, shifts and optionally saturates each result to an 18-bit word. Results are buffered in a small first-word-fall-through FIFO and presented to the next consumer over a valid/ready handshake. It decouples the fixed-latency DSP pipeline from a consumer that may stall.

## Interface
- `IN_W`, 48, input result width (signed two's complement).
- `OUT_W`, 18, output word width (signed).
- `SHIFT`, 17, arithmetic right shift applied before narrowing; legal range 0..`IN_W`-`OUT_W`.
- `DEPTH`, 4, FIFO depth; power of two, ≥2.
- `AW`, 2, log2(`DEPTH`).

Ports:
- `CLK`  in  1  single clock; all state changes on its rising edge.
- `RSTN`  in  1  asynchronous, active-low reset.
- `P`  in  `IN_W`  DSP result.
- `CARRYOUT`  in  1  DSP carry, carried alongside the word.
- `P_VALID`  in  1  `P`/`CARRYOUT` valid this cycle.
- `P_READY`  out  1  packer accepts this cycle.
- `SAT_EN`  in  1  1 = saturate, 0 = wrap (truncate); sampled with each accepted word.
- `DOUT`  out  `OUT_W`  FIFO head word.
- `DOUT_CARRY`  out  1  carry bit of head word.
- `DOUT_SAT`  out  1  head word was out of range (clamped or wrapped).
- `DOUT_VALID`  out  1  FIFO non-empty.
- `DOUT_READY`  in  1  consumer pops head when high with `DOUT_VALID`.
- `COUNT`  out  `AW`+1  words stored in the FIFO (excludes stage S1).
- `OVF_STICKY`  out  1  set by any out-of-range word written to the FIFO.
- `CLR_OVF`  in  1  synchronous clear of `OVF_STICKY`.

## Operation
- Accept: a transfer occurs on an edge where `P_VALID` & `P_READY` are both high.
- `P_READY` = (`COUNT` + `s1_valid`) < `DEPTH`. This space reservation is conservative: a same-cycle pop does not raise it. A word in S1 is therefore never blocked from the FIFO.
- Stage S1, registered on accept: holds the processed word, carry, range flag and `s1_valid`. When there is no accept, `s1_valid` goes to 0 at the next edge.
- Arithmetic in S1, in this order:
  - sign-extend `P` to `IN_W`+1 bits;
  - add 2^(`SHIFT`-1) for round-half-up; no add when `SHIFT`=0;
  - arithmetic shift right by `SHIFT`, giving `q`.
- Range check: out of range if `q` > 2^(`OUT_W`-1)-1 or `q` < -2^(`OUT_W`-1).
  - `SAT_EN`=1: out-of-range `q` clamps to 0x1FFFF (positive) or 0x20000 (negative).
  - `SAT_EN`=0: low `OUT_W` bits of `q` are kept.
  - The range flag is set in both cases.
- FIFO write: when `s1_valid`=1, S1 is written at `wr_ptr` and `wr_ptr` increments, wrapping modulo `DEPTH`.
- FIFO read: the head is visible combinationally from `mem[rd_ptr]`. A pop (`DOUT_VALID` & `DOUT_READY`) increments `rd_ptr`, wrapping.
- `COUNT`:
  - write only: +1;
  - pop only: -1;
  - write and pop on the same edge: unchanged, and both pointers advance.
- `DOUT`, `DOUT_CARRY` and `DOUT_SAT` are forced to 0 while empty.
- `OVF_STICKY` is set on the edge a flagged word is written to the FIFO. It is cleared by `CLR_OVF`; when both happen on the same edge, set wins.
- A pop while empty is ignored. A write is never attempted while full, guaranteed by the reservation rule.

## Timing
- Reset (`RSTN`=0, asynchronous, effective mid-operation) clears:
  - `s1_valid`, both pointers, `COUNT`, `OVF_STICKY`;
  - outputs take `P_READY`=1 and `DOUT_VALID`=`DOUT`=`DOUT_CARRY`=`DOUT_SAT`=0.
- Words in S1 or the FIFO at reset are discarded. FIFO memory itself is not reset.
- Latency: a word accepted at edge k reaches S1 at edge k and the FIFO at edge k+1. `DOUT_VALID` rises in the cycle after edge k+1 when the FIFO was empty, so the minimum input-to-output latency is 2 edges.
- Throughput: 1 word/cycle sustained while `DOUT_READY`=1.
- `P_READY` depends only on registered state, so there is no combinational path from `DOUT_READY`.

## Test plan
- Reset, then check idle values: `P_READY`=1, `DOUT_VALID`=0, `COUNT`=0, `OVF_STICKY`=0. Assert `RSTN` with 3 words buffered; all outputs must return to reset values immediately.
- Rounding, with `SAT_EN`=1:
  - `P`=393216 (3·2^17) → `DOUT`=3;
  - `P`=458752 (3.5·2^17) → 4;
  - `P`=-65536 → 0;
  - `P`=-196608 → -1.
  - `DOUT_SAT`=0 for all four; first `DOUT_VALID` two edges after accept.
- Saturation and wrap:
  - `P`=2^40 with `SAT_EN`=1 → `DOUT`=0x1FFFF, `DOUT_SAT`=1, `OVF_STICKY`=1;
  - `P`=-2^40 → 0x20000;
  - `P`=2^40 with `SAT_EN`=0 → `DOUT`=0, `DOUT_SAT`=1.
  - `CLR_OVF` clears the sticky; `CLR_OVF` coincident with a flagged write leaves it at 1.
- Full: hold `DOUT_READY`=0 and drive `P_VALID`=1 continuously. Exactly 4 words are accepted, `P_READY`=0 from the cycle after the 4th accept, and `COUNT` settles at 4. Release `DOUT_READY`: the 4 words pop in order, then `P_READY` returns to 1.
- Simultaneous push and pop: stream 10 words with `DOUT_READY`=1 after the first arrives.
  - `COUNT` stays at 1, pointers wrap past `DEPTH`, output order and `DOUT_CARRY` match input.
- Empty pop: `DOUT_READY`=1 while empty → no pointer or `COUNT` change, `DOUT`=0.
